// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE
   } sched_state_e;

   localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap-around.
module uart_tx_rr_arb #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_grant,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] gnt_idx,
   output logic                     any
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      // Candidate order: last_grant+1, last_grant+2, ..., last_grant (lowest priority).
      for (int i = 1; i <= N_REQ; i++) begin
         idx = IDX_W'((int'(last_grant) + i) % N_REQ);
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt_idx  = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers,
// sequencing exactly one frame at a time against the transmitter's Busy flag.
module uart_tx_sched
   import uart_tx_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*UART_DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]             req_par_en,
   input  logic [N_REQ-1:0]             req_par_typ,
   output logic [UART_DATA_W-1:0]       P_DATA,
   output logic                         PAR_EN,
   output logic                         PAR_TYP,
   output logic                         DATA_VALID,
   input  logic                         Busy,
   output logic [$clog2(N_REQ)-1:0]     grant_id,
   output logic                         tx_active,
   output logic                         timeout_err
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   sched_state_e           state_q;
   logic [IDX_W-1:0]       last_grant_q;
   logic [IDX_W-1:0]       grant_id_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [UART_DATA_W-1:0] p_data_q;
   logic                   par_en_q;
   logic                   par_typ_q;
   logic                   data_valid_q;
   logic                   tx_active_q;
   logic                   timeout_err_q;

   logic [UART_DATA_W-1:0] req_bytes [N_REQ];
   logic [N_REQ-1:0]       arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_any;
   logic                   grant;

   for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[g*UART_DATA_W +: UART_DATA_W];
   end

   uart_tx_rr_arb #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx),
      .any        (arb_any)
   );

   // A grant only happens in IDLE with the transmitter free; reset masks it too.
   assign grant     = (state_q == IDLE) && !Busy && arb_any && !reset;
   assign req_ready = grant ? arb_gnt : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= IDX_W'(N_REQ - 1);
         grant_id_q    <= '0;
         cnt_q         <= '0;
         p_data_q      <= '0;
         par_en_q      <= 1'b0;
         par_typ_q     <= 1'b0;
         data_valid_q  <= 1'b0;
         tx_active_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         data_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant) begin
                  p_data_q     <= req_bytes[arb_idx];
                  par_en_q     <= req_par_en[arb_idx];
                  par_typ_q    <= req_par_typ[arb_idx];
                  last_grant_q <= arb_idx;
                  grant_id_q   <= arb_idx;
                  data_valid_q <= 1'b1;
                  tx_active_q  <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT_START;
            end
            WAIT_START: begin
               // Busy wins over an expiring timeout in the same cycle.
               if (Busy) begin
                  state_q <= WAIT_DONE;
               end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                  timeout_err_q <= 1'b1;
                  tx_active_q   <= 1'b0;
                  state_q       <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!Busy) begin
                  tx_active_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               tx_active_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign P_DATA      = p_data_q;
   assign PAR_EN      = par_en_q;
   assign PAR_TYP     = par_typ_q;
   assign DATA_VALID  = data_valid_q;
   assign grant_id    = grant_id_q;
   assign tx_active   = tx_active_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench: plays the transmitter side and predicts grants and timing per frame.
module tb_uart_tx_sched;

   localparam int NR = 4;
   localparam int BT = 4;

   logic          clk;
   logic          reset;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_ready;
   logic [31:0]   req_data;
   logic [NR-1:0] req_par_en;
   logic [NR-1:0] req_par_typ;
   logic [7:0]    P_DATA;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic          DATA_VALID;
   logic          Busy;
   logic [1:0]    grant_id;
   logic          tx_active;
   logic          timeout_err;

   int checks;
   int failures;
   int model_last;

   uart_tx_sched #(
      .N_REQ        (NR),
      .BUSY_TIMEOUT (BT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_data    (req_data),
      .req_par_en  (req_par_en),
      .req_par_typ (req_par_typ),
      .P_DATA      (P_DATA),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .DATA_VALID  (DATA_VALID),
      .Busy        (Busy),
      .grant_id    (grant_id),
      .tx_active   (tx_active),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Spec rule: first valid requester upward from the last grant, wrapping.
   function automatic int pick(input int last, input logic [NR-1:0] v);
      for (int i = 1; i <= NR; i++) begin
         if (v[(last + i) % NR]) return (last + i) % NR;
      end
      return -1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_pdata"}, 32'(P_DATA), 0);
      check_eq({tag, "_paren"}, 32'(PAR_EN), 0);
      check_eq({tag, "_partyp"}, 32'(PAR_TYP), 0);
      check_eq({tag, "_dv"}, 32'(DATA_VALID), 0);
      check_eq({tag, "_gid"}, 32'(grant_id), 0);
      check_eq({tag, "_active"}, 32'(tx_active), 0);
      check_eq({tag, "_tmo"}, 32'(timeout_err), 0);
      check_eq({tag, "_ready"}, 32'(req_ready), 0);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      Busy      = 1'b0;
      req_valid = '0;
      #3;
      check_reset_outputs("rst");
      tick();
      tick();
      #3;
      reset = 1'b0;
      tick();
      model_last = NR - 1;
   endtask

   // Entered and left in an idle cycle, at posedge+1.
   // gate: idle cycles with Busy held high; d: Busy rise delay (>BT means never); len: Busy length.
   task automatic run_frame(input logic [NR-1:0] valid, input logic [31:0] data,
                            input logic [NR-1:0] pen, input logic [NR-1:0] ptyp,
                            input int gate, input int d, input int len);
      int w;
      logic [7:0] exp_byte;
      req_valid   = valid;
      req_data    = data;
      req_par_en  = pen;
      req_par_typ = ptyp;
      for (int g = 0; g < gate; g++) begin
         Busy = 1'b1;
         #1;
         check_eq("gate_ready", 32'(req_ready), 0);
         tick();
         check_eq("gate_dv", 32'(DATA_VALID), 0);
      end
      Busy = 1'b0;
      w = pick(model_last, valid);
      exp_byte = data[8*w +: 8];
      #1;
      check_eq("grant_ready", 32'(req_ready), 32'(1 << w));
      check_eq("idle_active", 32'(tx_active), 0);
      tick();
      check_eq("issue_dv", 32'(DATA_VALID), 1);
      check_eq("issue_pdata", 32'(P_DATA), 32'(exp_byte));
      check_eq("issue_paren", 32'(PAR_EN), 32'(pen[w]));
      check_eq("issue_partyp", 32'(PAR_TYP), 32'(ptyp[w]));
      check_eq("issue_gid", 32'(grant_id), 32'(w));
      check_eq("issue_active", 32'(tx_active), 1);
      model_last = w;
      req_valid = NR'($urandom);
      #1;
      check_eq("issue_ready", 32'(req_ready), 0);
      if (d <= BT) begin
         for (int k = 1; k < d; k++) begin
            tick();
            #1;
            check_eq("ws_ready", 32'(req_ready), 0);
            check_eq("ws_dv", 32'(DATA_VALID), 0);
            check_eq("ws_tmo", 32'(timeout_err), 0);
         end
         tick();
         Busy = 1'b1;
         for (int l = 1; l < len; l++) begin
            tick();
            #1;
            check_eq("busy_dv", 32'(DATA_VALID), 0);
            check_eq("busy_active", 32'(tx_active), 1);
            check_eq("busy_pdata", 32'(P_DATA), 32'(exp_byte));
            check_eq("busy_ready", 32'(req_ready), 0);
         end
         tick();
         Busy = 1'b0;
         #1;
         check_eq("fall_active", 32'(tx_active), 1);
         check_eq("fall_ready", 32'(req_ready), 0);
         tick();
         check_eq("done_active", 32'(tx_active), 0);
         check_eq("done_tmo", 32'(timeout_err), 0);
         check_eq("done_pdata", 32'(P_DATA), 32'(exp_byte));
      end else begin
         for (int k = 1; k <= BT; k++) begin
            tick();
            #1;
            check_eq("tmo_wait", 32'(timeout_err), 0);
            check_eq("tmo_wait_active", 32'(tx_active), 1);
            check_eq("tmo_wait_ready", 32'(req_ready), 0);
         end
         tick();
         check_eq("tmo_pulse", 32'(timeout_err), 1);
         check_eq("tmo_active", 32'(tx_active), 0);
      end
      req_valid = '0;
   endtask

   task automatic idle_gap(input int n);
      req_valid = '0;
      for (int i = 0; i < n; i++) begin
         #1;
         check_eq("gap_ready", 32'(req_ready), 0);
         tick();
         check_eq("gap_dv", 32'(DATA_VALID), 0);
         check_eq("gap_active", 32'(tx_active), 0);
         check_eq("gap_tmo", 32'(timeout_err), 0);
      end
   endtask

   task automatic reset_mid_frame();
      req_valid   = 4'b0100;
      req_data    = 32'h00C3_0000;
      req_par_en  = 4'b0100;
      req_par_typ = 4'b0100;
      Busy        = 1'b0;
      #1;
      check_eq("rmf_ready", 32'(req_ready), 32'h4);
      tick();
      check_eq("rmf_dv", 32'(DATA_VALID), 1);
      req_valid = '0;
      tick();
      Busy = 1'b1;
      tick();
      check_eq("rmf_active", 32'(tx_active), 1);
      check_eq("rmf_pdata", 32'(P_DATA), 32'hC3);
      #2;
      reset = 1'b1;
      Busy  = 1'b0;
      #1;
      check_reset_outputs("rmf");
      tick();
      check_eq("rmf_hold_dv", 32'(DATA_VALID), 0);
      #3;
      reset = 1'b0;
      tick();
      check_eq("rmf_post_dv", 32'(DATA_VALID), 0);
      check_eq("rmf_post_active", 32'(tx_active), 0);
      model_last = NR - 1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      model_last  = NR - 1;
      reset       = 1'b1;
      Busy        = 1'b0;
      req_valid   = '0;
      req_data    = '0;
      req_par_en  = '0;
      req_par_typ = '0;
      tick();
      do_reset();
      check_reset_outputs("post_rst");

      // Single request from requester 1 with odd parity.
      run_frame(4'b0010, 32'h0000_A500, 4'b0010, 4'b0010, 0, 2, 3);
      check_eq("single_gid", 32'(grant_id), 1);
      check_eq("single_pdata_hold", 32'(P_DATA), 32'hA5);
      idle_gap(2);
      check_eq("single_paren_hold", 32'(PAR_EN), 1);
      check_eq("single_partyp_hold", 32'(PAR_TYP), 1);

      // Fairness: all valid after reset must yield 0,1,2,3,0.
      do_reset();
      for (int f = 0; f < 5; f++) begin
         run_frame(4'b1111, $urandom, NR'($urandom), NR'($urandom), 0, 1, 2);
         check_eq("fair_order", 32'(grant_id), 32'(f % NR));
      end

      // Busy gating in IDLE, then back-to-back frames on requester 2.
      run_frame(4'b0001, $urandom, 4'b0001, 4'b0000, 3, 3, 1);
      run_frame(4'b0100, $urandom, 4'b0000, 4'b0100, 0, 1, 4);
      run_frame(4'b0100, $urandom, 4'b0100, 4'b0000, 0, 2, 1);

      // Timeout, then the next requester wins the following grant.
      run_frame(4'b1111, $urandom, NR'($urandom), NR'($urandom), 0, BT + 1, 1);
      run_frame(4'b1111, $urandom, NR'($urandom), NR'($urandom), 0, BT, 2);
      idle_gap(1);

      reset_mid_frame();
      run_frame(4'b1001, $urandom, NR'($urandom), NR'($urandom), 0, 2, 2);
      check_eq("rmf_first_gid", 32'(grant_id), 0);

      for (int n = 0; n < 60; n++) begin
         int gate;
         gate = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         run_frame(NR'($urandom_range(1, 15)), $urandom, NR'($urandom), NR'($urandom), gate,
                   int'($urandom_range(1, BT + 1)), int'($urandom_range(1, 5)));
         if ($urandom_range(0, 4) == 0) idle_gap(int'($urandom_range(1, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
